// File: rtl/mux_scan_sel.sv
// rtl/mux_scan_sel.sv - registered N:1 multi-bit mux with manual select and masked round-robin scan
module mux_scan_sel #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2,
  parameter int DWELL    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      EN,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          S,
  input  logic [CHANNELS-1:0]       MASK,
  input  logic [CHANNELS*WIDTH-1:0] I,
  output logic [WIDTH-1:0]          Y,
  output logic [SEL_W-1:0]          CH,
  output logic                      VALID,
  output logic                      WRAP
);

  localparam logic [SEL_W:0] NCH        = (SEL_W+1)'(CHANNELS);
  localparam logic [7:0]     DWELL_LAST = 8'(DWELL - 1);

  logic [SEL_W-1:0] ptr;
  logic [7:0]       dwell_cnt;
  logic             mode_q;
  // wrap is decided when ptr jumps back; the pulse is emitted one cycle later
  // so it lines up with the first output taken from the wrapped-to channel
  logic             wrap_pend;

  logic             s_ok;
  logic [WIDTH-1:0] s_data;
  logic [WIDTH-1:0] p_data;
  logic             ptr_masked;
  logic             all_masked;
  logic             advance;
  logic [SEL_W-1:0] nxt_hi;
  logic             hi_found;
  logic [SEL_W-1:0] nxt_lo;
  logic             lo_found;

  assign s_ok       = ({1'b0, S} < NCH);
  assign all_masked = &MASK;
  assign advance    = ptr_masked || (dwell_cnt == DWELL_LAST);

  // channel lookup for S and ptr, and next unmasked channel above ptr / lowest overall
  always_comb begin
    s_data     = '0;
    p_data     = '0;
    ptr_masked = 1'b0;
    nxt_hi     = '0;
    hi_found   = 1'b0;
    nxt_lo     = '0;
    lo_found   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (SEL_W'(k) == S) begin
        s_data = I[k*WIDTH +: WIDTH];
      end
      if (SEL_W'(k) == ptr) begin
        p_data     = I[k*WIDTH +: WIDTH];
        ptr_masked = MASK[k];
      end
      if (!MASK[k] && !lo_found) begin
        nxt_lo   = SEL_W'(k);
        lo_found = 1'b1;
      end
      if (!MASK[k] && !hi_found && (SEL_W'(k) > ptr)) begin
        nxt_hi   = SEL_W'(k);
        hi_found = 1'b1;
      end
    end
  end

  // registered outputs plus scan pointer, dwell counter and mode history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      Y         <= '0;
      CH        <= '0;
      VALID     <= 1'b0;
      WRAP      <= 1'b0;
      ptr       <= '0;
      dwell_cnt <= '0;
      mode_q    <= 1'b0;
      wrap_pend <= 1'b0;
    end else begin
      mode_q <= MODE;
      if (!EN) begin
        Y     <= '0;
        VALID <= 1'b0;
        WRAP  <= 1'b0;
      end else if (!MODE) begin
        Y         <= s_ok ? s_data : '0;
        CH        <= S;
        VALID     <= s_ok;
        WRAP      <= 1'b0;
        wrap_pend <= 1'b0;
      end else if (!mode_q) begin
        Y         <= p_data;
        CH        <= ptr;
        VALID     <= 1'b0;
        WRAP      <= 1'b0;
        wrap_pend <= 1'b0;
        ptr       <= s_ok ? S : '0;
        dwell_cnt <= '0;
      end else if (all_masked) begin
        Y         <= '0;
        CH        <= ptr;
        VALID     <= 1'b0;
        WRAP      <= 1'b0;
        wrap_pend <= 1'b0;
      end else begin
        Y     <= p_data;
        CH    <= ptr;
        VALID <= ~ptr_masked;
        WRAP  <= wrap_pend;
        if (advance) begin
          ptr       <= hi_found ? nxt_hi : nxt_lo;
          wrap_pend <= ~hi_found;
          dwell_cnt <= '0;
        end else begin
          dwell_cnt <= dwell_cnt + 8'd1;
          wrap_pend <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sel.sv
// tb/tb_mux_scan_sel.sv - randomized and directed bench for mux_scan_sel against a behavioural model
module tb_mux_scan_sel;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int SW = 2;
  localparam int DW = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         EN;
  logic         MODE;
  logic [SW-1:0] S;
  logic [N-1:0] MASK;
  logic [N*W-1:0] I;
  logic [W-1:0] Y;
  logic [SW-1:0] CH;
  logic         VALID;
  logic         WRAP;
  logic [W-1:0] Y3;
  logic [SW-1:0] CH3;
  logic         VALID3;
  logic         WRAP3;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int       m_ptr;
  int       m_dwell;
  bit       m_modeq;
  bit       m_pend;
  logic [W-1:0] e_y;
  int       e_ch;
  bit       e_v;
  bit       e_w;

  always #5 clk = ~clk;

  mux_scan_sel #(.WIDTH(W), .CHANNELS(N), .SEL_W(SW), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .EN(EN), .MODE(MODE), .S(S), .MASK(MASK), .I(I),
    .Y(Y), .CH(CH), .VALID(VALID), .WRAP(WRAP)
  );

  mux_scan_sel #(.WIDTH(W), .CHANNELS(3), .SEL_W(SW), .DWELL(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .EN(EN), .MODE(MODE), .S(S), .MASK(MASK[2:0]), .I(I[3*W-1:0]),
    .Y(Y3), .CH(CH3), .VALID(VALID3), .WRAP(WRAP3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chd(input int k);
    return I[k*W +: W];
  endfunction

  // advance the model by one clock using the current inputs
  task automatic model_step();
    int um[$];
    int nxt;
    if (!rst_n) begin
      e_y = '0; e_ch = 0; e_v = 0; e_w = 0;
      m_ptr = 0; m_dwell = 0; m_modeq = 0; m_pend = 0;
      return;
    end
    if (!EN) begin
      e_y = '0; e_v = 0; e_w = 0;
    end else if (!MODE) begin
      e_ch = S; e_v = (S < N); e_y = e_v ? chd(S) : '0; e_w = 0; m_pend = 0;
    end else if (!m_modeq) begin
      e_ch = m_ptr; e_y = chd(m_ptr); e_v = 0; e_w = 0; m_pend = 0;
      m_ptr = (S < N) ? int'(S) : 0;
      m_dwell = 0;
    end else begin
      for (int k = 0; k < N; k++) if (!MASK[k]) um.push_back(k);
      e_ch = m_ptr;
      if (um.size() == 0) begin
        e_y = '0; e_v = 0; e_w = 0; m_pend = 0;
      end else begin
        e_y = chd(m_ptr); e_v = !MASK[m_ptr]; e_w = m_pend;
        if (MASK[m_ptr] || m_dwell == DW - 1) begin
          nxt = -1;
          foreach (um[i]) if (nxt < 0 && um[i] > m_ptr) nxt = um[i];
          m_pend = (nxt < 0);
          if (nxt < 0) nxt = um[0];
          m_ptr = nxt;
          m_dwell = 0;
        end else begin
          m_dwell++;
          m_pend = 0;
        end
      end
    end
    m_modeq = MODE;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("Y", Y, e_y);
    check("CH", CH, e_ch);
    check("VALID", VALID, e_v);
    check("WRAP", WRAP, e_w);
  endtask

  initial begin : stim
    int ch_seq[9];
    int skip_seq[6];
    ch_seq   = '{1, 1, 2, 2, 3, 3, 0, 0, 1};
    skip_seq = '{1, 1, 3, 3, 1, 1};
    m_ptr = 0; m_dwell = 0; m_modeq = 0; m_pend = 0;
    e_y = '0; e_ch = 0; e_v = 0; e_w = 0;

    // reset with nonzero data
    rst_n = 0; EN = 1; MODE = 0; S = 2; MASK = '0; I = 32'hDEADBEEF;
    step();
    step();
    check("rst_Y", Y, 0);
    check("rst_VALID", VALID, 0);

    // release, manual select of channel 2
    rst_n = 1; MODE = 0; S = 2; I = 32'h00A50000;
    step();
    check("man_A5", Y, 8'hA5);
    check("man_CH2", CH, 2);

    // manual sweep, also on the 3-channel instance
    I = 32'h44332211;
    for (int s = 0; s < 4; s++) begin
      S = s[SW-1:0];
      step();
      check("sweep_Y", Y, 8'h11 * (s + 1));
      check("ch3_Y", Y3, (s < 3) ? 8'h11 * (s + 1) : 0);
      check("ch3_CH", CH3, s);
      check("ch3_VALID", VALID3, s < 3);
    end

    // scan from channel 1, no mask
    MODE = 1; S = 1; MASK = 4'b0000;
    step();
    check("entry_VALID", VALID, 0);
    for (int i = 0; i < 9; i++) begin
      step();
      check("scan_CH", CH, ch_seq[i]);
      check("scan_WRAP", WRAP, i == 6);
    end

    // scan with channels 0 and 2 skipped
    MODE = 0; step();
    MODE = 1; S = 1; MASK = 4'b0101;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      check("skip_CH", CH, skip_seq[i]);
      check("skip_WRAP", WRAP, i == 4);
    end
    MASK = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      step();
      check("allmask_VALID", VALID, 0);
      check("allmask_Y", Y, 0);
      check("allmask_WRAP", WRAP, 0);
    end

    // EN hold mid-dwell, then reset pulse
    MASK = 4'b0000; MODE = 0; step();
    MODE = 1; S = 2; step();
    step();
    check("en_pre_CH", CH, 2);
    EN = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_hold_Y", Y, 0);
      check("en_hold_VALID", VALID, 0);
      check("en_hold_CH", CH, 2);
    end
    EN = 1;
    step();
    check("en_resume_CH", CH, 2);
    step();
    check("en_next_CH", CH, 3);
    rst_n = 0;
    step();
    check("midrst_CH", CH, 0);
    check("midrst_VALID", VALID, 0);
    rst_n = 1;

    // current channel becomes masked
    MODE = 0; step();
    MODE = 1; S = 2; step();
    MASK = 4'b0100;
    step();
    check("mcur_VALID", VALID, 0);
    check("mcur_CH", CH, 2);
    step();
    check("mcur_next_CH", CH, 3);

    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      EN    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) MODE = ~MODE;
      if ($urandom_range(0, 3) == 0) S = SW'($urandom);
      if ($urandom_range(0, 7) == 0) MASK = N'($urandom);
      I = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_scan_sel.md
Name: mux_scan_sel

Overview:
- Parametrised, registered N:1 multi-bit multiplexer. It is the clocked successor of the 4:1 one-bit enable mux.
- Two modes:
  - Manual: an external select chooses the channel.
  - Scan: an internal pointer round-robins through the channels that are not masked, dwelling a fixed number of cycles on each.
- Sits between the gate-level datapath channels and downstream sampling/display logic.

Parameters:
- WIDTH, 8, data bits per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/pointer width; ceil(log2(CHANNELS)), minimum 1.
- DWELL, 2, cycles spent on each channel in scan mode (1..255).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- EN  input  1  enable; 0 forces the output to zero and freezes the scan.
- MODE  input  1  0 = manual select, 1 = scan.
- S  input  SEL_W  manual channel select.
- MASK  input  CHANNELS  bit k = 1 means channel k is skipped in scan mode (ignored in manual mode).
- I  input  CHANNELS*WIDTH  packed channel data; channel k = I[k*WIDTH +: WIDTH].
- Y  output  WIDTH  registered selected data.
- CH  output  SEL_W  channel index that Y was taken from.
- VALID  output  1  Y holds real channel data.
- WRAP  output  1  one-cycle pulse when the scan pointer wraps.

Behaviour:
- All state is updated on the rising edge of clk. Reset is synchronous: rst_n=0 at an edge gives Y=0, CH=0, VALID=0, WRAP=0, ptr=0, dwell_cnt=0, mode_q=0.
- Reset asserted mid-scan takes effect at the next edge, with no partial update. The first edge with rst_n=1 performs normal operation.
- Latency: 1 cycle. Y, CH and VALID at edge t+1 reflect I, S, MODE, EN and the pointer at edge t.
- EN=0:
  - Next-cycle outputs: Y=0, VALID=0, WRAP=0.
  - CH, ptr and dwell_cnt hold.
  - mode_q still tracks MODE.
- Manual mode (MODE=1'b0, EN=1):
  - S < CHANNELS: Y = channel S, CH = S, VALID = 1.
  - S >= CHANNELS: Y = 0, CH = S, VALID = 0.
  - ptr and dwell_cnt hold.
- Scan entry: when MODE=1 and mode_q=0, ptr loads S if S < CHANNELS, else 0; dwell_cnt = 0. Outputs that cycle reflect the old ptr with VALID=0.
- Scan mode (MODE=1, EN=1, mode_q=1), each cycle:
  - Y = channel ptr, CH = ptr, VALID = ~MASK[ptr].
  - ptr is masked: advance at once, ignoring dwell.
  - Otherwise, if dwell_cnt == DWELL-1: advance and set dwell_cnt = 0.
  - Otherwise: dwell_cnt increments.
- Advance rule:
  - New ptr is the lowest unmasked index greater than ptr.
  - If there is none, it is the lowest unmasked index overall (a wrap), and WRAP=1 in the next cycle.
  - If ptr is the only unmasked channel, ptr stays and WRAP pulses each dwell period.
  - If all channels are masked, ptr holds, VALID=0, Y=0 and WRAP=0.
- DWELL=1: advance every cycle.
- WRAP is high for exactly one cycle per wrap and is otherwise 0.
- MASK changes take effect at the next edge.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with I nonzero → Y=0, CH=0, VALID=0, WRAP=0. Release and set MODE=0, S=2, I ch2=8'hA5 → one cycle later Y=8'hA5, CH=2, VALID=1.
- Manual select sweep: S=0..3 with channel data 11,22,33,44 → Y follows with 1-cycle lag. With CHANNELS=3 and S=3 → Y=0, VALID=0.
- Scan, DWELL=2, MASK=0, start S=1: CH sequence is 1,1,2,2,3,3,0,0,1. WRAP pulses in the first cycle with CH=0.
- Scan skip, MASK=4'b0101: CH sequence is 1,1,3,3,1,1. WRAP pulses in the cycle CH returns to 1. Set MASK=4'b1111 → VALID=0, Y=0, CH held, no WRAP.
- EN and reset mid-scan: EN=0 for 3 cycles at CH=2 with dwell_cnt=1 → Y=0 and VALID=0 during the hold, then the scan resumes at CH=2 for 1 more cycle. A later rst_n=0 pulse at any point → all outputs 0 at the next edge.
- Masked current channel: ptr=2, set MASK[2]=1 → that cycle VALID=0, and the next cycle CH=3 regardless of dwell.
